rv_writeback_lq: RTL and testbench
==================================

// Module: rv_writeback_lq
// PURPOSE
//  Writeback stage with a parametrised in-order load queue (LQ): up to LQ_DEPTH loads may be
//  outstanding, so the X stage no longer waits per load. Sits between execute and the register
//  file. Aligns/extends returned load data, arbitrates LQ returns vs. ALU/shifter/multiply
//  results onto the single RF write port, and registers the RF write (1-cycle latency).
// PARAMETERS
//  LQ_DEPTH        2    outstanding-load entries; power of two, 2..8
//  TIMEOUT_CYCLES  255  load watchdog limit (RV_WB_LOAD_TIMEOUT_EN only), 1..65535
// PORTS
//  clk_i                   in   1   clock
//  rst_n_i                 in   1   async reset, active low
//  w_stall_i               in   1   pipeline stall: no push, no non-load write
//  w_stall_req_o           out  1   stall request to pipeline (combinational)
//  x_valid_i               in   1   X-stage instruction valid
//  x_fun_i                 in   3   LDST_B/BU/H/HU/L function code
//  x_load_i / x_store_i    in   1   instruction is a load / store
//  x_dm_addr_i             in   2   low bits of data-memory address
//  x_rd_i                  in   5   destination register
//  x_rd_write_i            in   1   instruction writes rd
//  x_rd_source_i           in   2   RD_SOURCE_* select (ALU/shifter/multiply)
//  x_rd_value_i, x_shifter_rd_value_i, x_multiply_rd_value_i  in 32  result candidates
//  dm_data_l_i             in   32  load return data (word, unaligned lanes)
//  dm_load_done_i          in   1   one-cycle pulse: oldest outstanding load returned
//  dm_store_done_i         in   1   store complete
//  rf_rd_value_o           out  32  RF write data (registered)
//  rf_rd_o                 out  5   RF write index (registered)
//  rf_rd_write_o           out  1   RF write enable (registered)
//  lq_pending_mask_o       out  32  bit r set while a queued load targets xr (bit 0 always 0)
//  lq_empty_o              out  1   no load outstanding
//  load_err_o              out  1   one-cycle pulse: load abandoned by watchdog
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): LQ flushed (rd/wr ptr, count = 0), rf_rd_value_o=0, rf_rd_o=0,
//    rf_rd_write_o=0, load_err_o=0, mask=0, lq_empty_o=1. Loads in flight are forgotten;
//    a dm_load_done_i after reset with LQ empty is ignored.
//  - Push: x_valid_i & x_load_i & !w_stall_i & !full -> entry {rd, fun, addr[1:0]} written at
//    wr ptr. rd=0 loads are queued (ordering) but never write the RF.
//  - Pop: dm_load_done_i & !empty -> head entry aligns dm_data_l_i per its fun/addr
//    (B/H sign-extend, BU/HU zero-extend, H uses addr[1] lane, L passes word); next cycle
//    rf_rd_* = {head.rd, aligned, head.rd!=0}. Push and pop in same cycle legal, incl. full.
//  - Non-load write: x_valid_i & x_rd_write_i & !x_load_i & !w_stall_i & no pop this cycle
//    -> registered next cycle; value by x_rd_source_i (shifter/multiply/else ALU).
//  - Port conflict: pop has priority; a colliding non-load write is held and
//    w_stall_req_o asserted that cycle; it retires the following free cycle.
//  - w_stall_req_o = (load & valid & full & !pop) | (x_store_i & !dm_store_done_i) |
//    conflict. Full with simultaneous pop accepts the push (no stall).
//  - Otherwise rf_rd_write_o=0 next cycle; rf_rd_value_o/rf_rd_o hold last value.
//  - Pointers wrap modulo LQ_DEPTH; count 0..LQ_DEPTH; mask is OR of valid entries' rd decode.
//  - Decode must stall on lq_pending_mask_o for RAW/WAW; this block does not check hazards.
// CONFIGURATION
//  RV_WB_LOAD_TIMEOUT_EN defined: 16-bit counter runs while LQ non-empty, cleared on pop/reset;
//    on reaching TIMEOUT_CYCLES head is popped with no RF write, load_err_o pulses 1 cycle,
//    counter clears. A dm_load_done_i in the same cycle wins (normal pop, no error).
//  Undefined: no counter, load_err_o tied 0, TIMEOUT_CYCLES unused; loads wait forever.
// TESTING
//  1 LB x5, addr[1:0]=3, done with data 32'h80_00_00_00 -> next cycle rd=5, value 32'hFFFFFF80, we=1.
//  2 LQ_DEPTH=2: LHU x6 @2, LW x7, third load -> w_stall_req_o=1 until first done; returns in
//    order: data 32'hBEEF_0000 -> x6=32'h0000BEEF, then x7 = raw word.
//  3 ADD x8 result 32'h1234 in same cycle as load pop for x9 -> x9 written first,
//    w_stall_req_o=1 one cycle, x8=32'h1234 written next cycle.
//  4 LW x0 then done -> rf_rd_write_o stays 0, LQ empties; mask bit 0 never set.
//  5 Two loads queued, assert rst_n_i low mid-flight -> all outputs 0, lq_empty_o=1;
//    stray dm_load_done_i after release causes no write.
//  6 RV_WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4: LW x3, no done -> load_err_o pulses after 4
//    cycles, no RF write, lq_empty_o=1; undefined build: load_err_o stays 0.

Source files
------------

// File: rtl/rv_writeback_lq.sv
// Writeback stage with an in-order load queue arbitrating load returns and ALU/shift/mul results onto one RF write port.
// Optional load watchdog enabled by defining RV_WB_LOAD_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module rv_writeback_lq #(
  parameter int LQ_DEPTH       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [31:0] rf_rd_value_o,
  output logic [4:0]  rf_rd_o,
  output logic        rf_rd_write_o,
  output logic [31:0] lq_pending_mask_o,
  output logic        lq_empty_o,
  output logic        load_err_o
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_L  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
  localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
  localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;

  logic [4:0]       ent_rd_reg   [LQ_DEPTH];
  logic [2:0]       ent_fun_reg  [LQ_DEPTH];
  logic [1:0]       ent_addr_reg [LQ_DEPTH];
  logic             ent_vld_reg  [LQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic        lq_empty;
  logic        lq_full;
  logic        pop_done;
  logic        timeout_pop;
  logic        pop_any;
  logic        push;
  logic        nl_req;
  logic        nl_write;
  logic        conflict;
  logic [4:0]  head_rd;
  logic [2:0]  head_fun;
  logic [1:0]  head_addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] aligned_value;
  logic [31:0] nl_value;

  assign lq_empty = (count_reg == '0);
  assign lq_full  = (count_reg == DEPTH_C);

  assign pop_done = dm_load_done_i & ~lq_empty;
  assign pop_any  = pop_done | timeout_pop;
  // A full queue still accepts a load in the same cycle the head leaves.
  assign push     = x_valid_i & x_load_i & ~w_stall_i & (~lq_full | pop_any);
  assign nl_req   = x_valid_i & x_rd_write_i & ~x_load_i & ~w_stall_i;
  assign conflict = nl_req & pop_done;
  assign nl_write = nl_req & ~pop_done;

  assign w_stall_req_o = (x_load_i & x_valid_i & lq_full & ~pop_any)
                       | (x_store_i & ~dm_store_done_i)
                       | conflict;

  assign head_rd   = ent_rd_reg[rd_ptr_reg];
  assign head_fun  = ent_fun_reg[rd_ptr_reg];
  assign head_addr = ent_addr_reg[rd_ptr_reg];

  assign load_byte = dm_data_l_i[{head_addr, 3'b000} +: 8];
  assign load_half = head_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

  always_comb begin
    aligned_value = dm_data_l_i;
    case (head_fun)
      LDST_B:  aligned_value = {{24{load_byte[7]}}, load_byte};
      LDST_BU: aligned_value = {24'd0, load_byte};
      LDST_H:  aligned_value = {{16{load_half[15]}}, load_half};
      LDST_HU: aligned_value = {16'd0, load_half};
      LDST_L:  aligned_value = dm_data_l_i;
      default: aligned_value = dm_data_l_i;
    endcase
  end

  always_comb begin
    case (x_rd_source_i)
      RD_SOURCE_SHIFTER:  nl_value = x_shifter_rd_value_i;
      RD_SOURCE_MULTIPLY: nl_value = x_multiply_rd_value_i;
      RD_SOURCE_ALU:      nl_value = x_rd_value_i;
      default:            nl_value = x_rd_value_i;
    endcase
  end

  // Entry storage; on a simultaneous pop+push of the same slot the push wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        ent_vld_reg[i]  <= 1'b0;
        ent_rd_reg[i]   <= 5'd0;
        ent_fun_reg[i]  <= 3'd0;
        ent_addr_reg[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (pop_any && (rd_ptr_reg == PTR_W'(i))) begin
          ent_vld_reg[i] <= 1'b0;
        end
        if (push && (wr_ptr_reg == PTR_W'(i))) begin
          ent_vld_reg[i]  <= 1'b1;
          ent_rd_reg[i]   <= x_rd_i;
          ent_fun_reg[i]  <= x_fun_i;
          ent_addr_reg[i] <= x_dm_addr_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop_any) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      case ({push, pop_any})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  logic [31:0] ent_mask [LQ_DEPTH];

  generate
    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_mask
      assign ent_mask[gi] = ent_vld_reg[gi] ? (32'd1 << ent_rd_reg[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    lq_pending_mask_o = 32'd0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      lq_pending_mask_o = lq_pending_mask_o | ent_mask[i];
    end
    lq_pending_mask_o[0] = 1'b0;
  end

  assign lq_empty_o = lq_empty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_rd_value_o <= 32'd0;
      rf_rd_o       <= 5'd0;
      rf_rd_write_o <= 1'b0;
    end else if (pop_done) begin
      rf_rd_value_o <= aligned_value;
      rf_rd_o       <= head_rd;
      rf_rd_write_o <= (head_rd != 5'd0);
    end else if (nl_write) begin
      rf_rd_value_o <= nl_value;
      rf_rd_o       <= x_rd_i;
      rf_rd_write_o <= 1'b1;
    end else begin
      rf_rd_write_o <= 1'b0;
    end
  end

`ifdef RV_WB_LOAD_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  logic [15:0] wd_cnt_reg;
  logic        load_err_reg;

  // A real load return in the same cycle takes precedence over the watchdog.
  assign timeout_pop = ~lq_empty & ~dm_load_done_i & (({1'b0, wd_cnt_reg} + 17'd1) == TIMEOUT_LIM);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_cnt_reg   <= 16'd0;
      load_err_reg <= 1'b0;
    end else begin
      load_err_reg <= timeout_pop;
      if (pop_any || lq_empty) begin
        wd_cnt_reg <= 16'd0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 16'd1;
      end
    end
  end

  assign load_err_o = load_err_reg;
`else
  logic unused_timeout_cfg;

  assign timeout_pop        = 1'b0;
  assign load_err_o         = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_rv_writeback_lq.sv
// Scoreboard bench for rv_writeback_lq: directed scenarios plus random traffic against a queue-based reference model.
module tb_rv_writeback_lq;

  localparam int DEPTH = 2;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_stall, w_stall_req;
  logic        x_valid, x_load, x_store, x_rd_write;
  logic [2:0]  x_fun;
  logic [1:0]  x_dm_addr, x_rd_source;
  logic [4:0]  x_rd;
  logic [31:0] x_rd_value, x_shifter_rd_value, x_multiply_rd_value;
  logic [31:0] dm_data_l;
  logic        dm_load_done, dm_store_done;
  logic [31:0] rf_rd_value;
  logic [4:0]  rf_rd;
  logic        rf_rd_write;
  logic [31:0] lq_pending_mask;
  logic        lq_empty, load_err;

  always #5 clk = ~clk;

  rv_writeback_lq #(.LQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .w_stall_i(w_stall), .w_stall_req_o(w_stall_req),
    .x_valid_i(x_valid), .x_fun_i(x_fun), .x_load_i(x_load), .x_store_i(x_store),
    .x_dm_addr_i(x_dm_addr), .x_rd_i(x_rd), .x_rd_write_i(x_rd_write),
    .x_rd_source_i(x_rd_source), .x_rd_value_i(x_rd_value),
    .x_shifter_rd_value_i(x_shifter_rd_value), .x_multiply_rd_value_i(x_multiply_rd_value),
    .dm_data_l_i(dm_data_l), .dm_load_done_i(dm_load_done), .dm_store_done_i(dm_store_done),
    .rf_rd_value_o(rf_rd_value), .rf_rd_o(rf_rd), .rf_rd_write_o(rf_rd_write),
    .lq_pending_mask_o(lq_pending_mask), .lq_empty_o(lq_empty), .load_err_o(load_err)
  );

  typedef struct packed {
    bit valid, load, store, store_done, rd_write, stall, done;
    logic [2:0] fun;
    logic [1:0] addr, src;
    logic [4:0] rd;
    logic [31:0] alu, shf, mul, ddata;
  } stim_t;

  typedef struct packed {logic [4:0] rd; logic [2:0] fun; logic [1:0] addr;} ent_t;
  typedef struct packed {bit we; logic [4:0] rd; logic [31:0] val; bit err; bit empty; logic [31:0] mask;} exp_t;

  ent_t lq_model[$];
  exp_t sb[$];
  int   wait_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [2:0] fun, input logic [1:0] addr, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * addr)) & 32'hFF;
    h = (w >> (16 * addr[1])) & 32'hFFFF;
    case (fun)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ld(input logic [4:0] rd, input logic [2:0] fun, input logic [1:0] addr);
    stim_t s;
    s = '0;
    s.valid = 1; s.load = 1; s.rd = rd; s.fun = fun; s.addr = addr;
    return s;
  endfunction

  // Drive one cycle, evaluate the reference model, queue the expected post-edge state.
  task automatic drive(input stim_t s);
    bit   empty_m, full_m, pop_done, fire, pop_any, nl, conflict, push, exp_stall;
    exp_t e;
    ent_t head;
    x_valid = s.valid; x_load = s.load; x_store = s.store; dm_store_done = s.store_done;
    x_rd_write = s.rd_write; w_stall = s.stall; dm_load_done = s.done;
    x_fun = s.fun; x_dm_addr = s.addr; x_rd_source = s.src; x_rd = s.rd;
    x_rd_value = s.alu; x_shifter_rd_value = s.shf; x_multiply_rd_value = s.mul;
    dm_data_l = s.ddata;
    #1;
    empty_m  = (lq_model.size() == 0);
    full_m   = (lq_model.size() == DEPTH);
    pop_done = s.done && !empty_m;
    fire     = 0;
`ifdef RV_WB_LOAD_TIMEOUT_EN
    fire = !empty_m && !s.done && (wait_cyc + 1 == TMO);
`endif
    pop_any   = pop_done || fire;
    nl        = s.valid && s.rd_write && !s.load && !s.stall;
    conflict  = nl && pop_done;
    push      = s.valid && s.load && !s.stall && (!full_m || pop_any);
    exp_stall = (s.load && s.valid && full_m && !pop_any) || (s.store && !s.store_done) || conflict;
    chk("stall_req", {31'd0, w_stall_req}, {31'd0, exp_stall});
    e = '0;
    if (pop_done) begin
      head  = lq_model[0];
      e.we  = (head.rd != 0);
      e.rd  = head.rd;
      e.val = ref_align(head.fun, head.addr, s.ddata);
    end else if (nl) begin
      e.we  = 1;
      e.rd  = s.rd;
      e.val = (s.src == 2'd1) ? s.shf : (s.src == 2'd2) ? s.mul : s.alu;
    end
    if (pop_any || empty_m) wait_cyc = 0;
    else wait_cyc++;
    if (pop_any) void'(lq_model.pop_front());
    if (push) lq_model.push_back('{rd: s.rd, fun: s.fun, addr: s.addr});
    e.err   = fire;
    e.empty = (lq_model.size() == 0);
    e.mask  = 0;
    foreach (lq_model[i]) e.mask = e.mask | (32'd1 << lq_model[i].rd);
    e.mask[0] = 1'b0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compares registered outputs after every edge that has an expectation queued.
  always @(posedge clk) begin
    exp_t m;
    #1;
    if (sb.size() != 0) begin
      m = sb.pop_front();
      chk("rf_we", {31'd0, rf_rd_write}, {31'd0, m.we});
      if (m.we) begin
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, m.rd});
        chk("rf_value", rf_rd_value, m.val);
      end
      chk("load_err", {31'd0, load_err}, {31'd0, m.err});
      chk("lq_empty", {31'd0, lq_empty}, {31'd0, m.empty});
      chk("pending_mask", lq_pending_mask, m.mask);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_value"}, rf_rd_value, 32'd0);
    chk({tag, "_rd"}, {27'd0, rf_rd}, 32'd0);
    chk({tag, "_we"}, {31'd0, rf_rd_write}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_mask"}, lq_pending_mask, 32'd0);
    chk({tag, "_empty"}, {31'd0, lq_empty}, 32'd1);
  endtask

  initial begin
    stim_t s;
    int    fsel;
    drive_idle_inputs();
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // LB x5 from byte lane 3, sign-extended
    drive(ld(5'd5, 3'd0, 2'd3));
    s = idle(); s.done = 1; s.ddata = 32'h8000_0000;
    drive(s);
    chk("t1_value", rf_rd_value, 32'hFFFF_FF80);
    chk("t1_rd", {27'd0, rf_rd}, 32'd5);
    chk("t1_we", {31'd0, rf_rd_write}, 32'd1);

    // Fill the queue, third load stalls until the head returns
    drive(ld(5'd6, 3'd5, 2'd2));
    drive(ld(5'd7, 3'd2, 2'd0));
    drive(ld(5'd10, 3'd2, 2'd0));
    s = ld(5'd10, 3'd2, 2'd0); s.done = 1; s.ddata = 32'hBEEF_0000;
    drive(s);
    chk("t2_x6", rf_rd_value, 32'h0000_BEEF);
    chk("t2_x6_rd", {27'd0, rf_rd}, 32'd6);
    s = idle(); s.done = 1; s.ddata = 32'hCAFE_F00D;
    drive(s);
    chk("t2_x7", rf_rd_value, 32'hCAFE_F00D);
    s = idle(); s.done = 1; s.ddata = 32'h0000_0042;
    drive(s);

    // ADD x8 collides with load pop for x9
    drive(ld(5'd9, 3'd2, 2'd0));
    s = idle(); s.valid = 1; s.rd_write = 1; s.rd = 5'd8; s.alu = 32'h1234;
    s.done = 1; s.ddata = 32'h0000_0099;
    drive(s);
    chk("t3_first_rd", {27'd0, rf_rd}, 32'd9);
    s.done = 0;
    drive(s);
    chk("t3_second_rd", {27'd0, rf_rd}, 32'd8);
    chk("t3_second_value", rf_rd_value, 32'h1234);

    // Load to x0 never writes and never sets mask bit 0
    drive(ld(5'd0, 3'd2, 2'd0));
    chk("t4_mask0", lq_pending_mask, 32'd0);
    s = idle(); s.done = 1; s.ddata = 32'hFFFF_FFFF;
    drive(s);
    chk("t4_we", {31'd0, rf_rd_write}, 32'd0);

    // Asynchronous reset with loads in flight
    drive(ld(5'd1, 3'd2, 2'd0));
    drive(ld(5'd2, 3'd2, 2'd0));
    drive_idle_inputs();
    #2 rst_n = 1'b0;
    #1 chk_reset_state("t5_async");
    lq_model.delete();
    wait_cyc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    s = idle(); s.done = 1; s.ddata = 32'h1111_1111;
    drive(s);
    chk("t5_stray_we", {31'd0, rf_rd_write}, 32'd0);

    // Load with no return: watchdog or wait forever depending on build
    drive(ld(5'd3, 3'd2, 2'd0));
    repeat (6) drive(idle());
`ifdef RV_WB_LOAD_TIMEOUT_EN
    chk("t6_empty", {31'd0, lq_empty}, 32'd1);
`else
    chk("t6_still_pending", {31'd0, lq_empty}, 32'd0);
    chk("t6_mask", lq_pending_mask, 32'h0000_0008);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.valid      = ($urandom_range(0, 9) < 7);
      s.load       = ($urandom_range(0, 9) < 4);
      s.rd_write   = $urandom_range(0, 1);
      s.store      = ($urandom_range(0, 9) == 0);
      s.store_done = $urandom_range(0, 1);
      s.stall      = ($urandom_range(0, 9) == 0);
      s.done       = ($urandom_range(0, 9) < 4);
      fsel         = $urandom_range(0, 4);
      s.fun        = (fsel == 0) ? 3'd0 : (fsel == 1) ? 3'd1 : (fsel == 2) ? 3'd2 : (fsel == 3) ? 3'd4 : 3'd5;
      s.addr       = 2'($urandom);
      s.src        = 2'($urandom);
      s.rd         = 5'($urandom);
      s.alu        = $urandom;
      s.shf        = $urandom;
      s.mul        = $urandom;
      s.ddata      = $urandom;
      drive(s);
    end

    for (int n = 0; n < DEPTH + 2; n++) begin
      s = idle(); s.done = 1; s.ddata = $urandom;
      drive(s);
    end
    drive(idle());
    chk("sb_drained", sb.size(), 32'd0);
    chk("final_empty", {31'd0, lq_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic drive_idle_inputs();
    x_valid = 0; x_load = 0; x_store = 0; dm_store_done = 0; x_rd_write = 0;
    w_stall = 0; dm_load_done = 0; x_fun = 0; x_dm_addr = 0; x_rd_source = 0;
    x_rd = 0; x_rd_value = 0; x_shifter_rd_value = 0; x_multiply_rd_value = 0;
    dm_data_l = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
